change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
- Downstream stage of the vending controller. It consumes the refund/change amount in 10-cent units (20 = $2.0, the same 10-bit money encoding the controller uses).
- Pays the amount out as timed coin-release pulses to four hopper solenoids, largest denomination first.
- Reports `busy`, the live `remaining` value for the 7-segment display, and a one-cycle `done`.

Parameters:
- PULSE_CYCLES, 10_000_000, clock cycles each coin-release pulse is held high (100 ms at 100 MHz)
- GAP_CYCLES, 10_000_000, clock cycles of all-low spacing after each pulse
- CNT_W, 24, width of the pulse/gap timer; must hold max(PULSE_CYCLES, GAP_CYCLES)

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  one-cycle request (from the PB_Capture-style trigger path or the controller REFUND entry)
- amount  input  10  change to pay, 10-cent units, 0..999
- hold  input  1  tray-full / pause; freezes the gap timer
- busy  output  1  high from the cycle after an accepted start through the done cycle
- coin_out  output  4  one-hot release: [3]=$10 (100), [2]=$5 (50), [1]=$2 (20), [0]=$1 (10)
- remaining  output  10  amount still to pay; display feeds it through Int_to_BCD
- coins_paid  output  4  coins released since last accepted start, saturates at 15
- done  output  1  one-cycle completion pulse
- short  output  1  high with done when remaining != 0 (residue < 10 not payable); held until next start

Behaviour:
- Reset (rst_n=0 at a clk edge) takes effect at that edge regardless of state:
  - busy, coin_out, remaining, coins_paid, done and short all go to 0.
  - State goes to IDLE and the timer goes to 0.
  - Reset mid-pulse drops coin_out on that same edge; no coin is counted.
- States: IDLE, SELECT, PULSE, GAP, DONE.
- IDLE:
  - busy=0, coin_out=0.
  - start=1 at an edge loads remaining<=amount, clears coins_paid and short, sets busy<=1, and moves to SELECT.
- SELECT (1 cycle):
  - Pick the largest denomination d <= remaining, priority 100 > 50 > 20 > 10.
  - If one is found: load timer with PULSE_CYCLES-1, drive coin_out with its one-hot, go to PULSE.
  - If none (remaining < 10): go to DONE.
- PULSE:
  - coin_out is held one-hot for exactly PULSE_CYCLES cycles; the timer decrements each cycle. hold is ignored here, so a pulse is never truncated or stretched.
  - On the cycle the timer reaches 0: remaining <= remaining - d, coins_paid += 1 (saturating), coin_out <= 0, load timer with GAP_CYCLES-1, go to GAP.
- GAP:
  - coin_out=0.
  - The timer decrements only when hold=0; hold=1 freezes it indefinitely.
  - At timer 0 with hold=0, go to SELECT.
- DONE (1 cycle): done=1, busy=1, short <= (remaining != 0). Then go to IDLE, where busy=0.
- start while busy=1 is ignored: no reload, amount not sampled.
- start coincident with the DONE cycle is ignored.
- Arithmetic:
  - Subtraction is 10-bit unsigned and never underflows, because d <= remaining by construction.
  - Greedy selection is exact for {100, 50, 20, 10} on multiples of 10.
- Latency:
  - amount=0: start edge → SELECT (1 cycle) → DONE (done high 2 cycles after the start edge).
  - Each coin costs 1 + PULSE_CYCLES + GAP_CYCLES cycles plus any hold time.
- coin_out is registered, glitch-free, and never has more than one bit set.

Test Plan (PULSE_CYCLES=4, GAP_CYCLES=2):
- amount=180, start → coin_out sequence 1000, 0100, 0010, 0001, each high exactly 4 cycles with 2 low cycles between. remaining steps 180→80→30→10→0. coins_paid=4, done pulse, short=0, total busy cycles 1+4*7+1=30.
- amount=35 → pulses $2 then $1, then done with remaining=5 and short=1. Next start with amount=0 clears short and gives done 2 cycles later with coins_paid=0.
- amount=300 → three consecutive $10 pulses, coins_paid=3. A start with amount=999 issued during the second pulse is ignored: remaining continues 200→100→0.
- hold=1 asserted for 10 cycles in the first GAP → gap lasts 12 cycles. hold=1 asserted during PULSE does not change the 4-cycle pulse width.
- rst_n=0 on cycle 2 of a $5 pulse (amount=50) → next edge: coin_out=0, remaining=0, coins_paid=0, busy=0, no done. After release, start with amount=20 pays a single $2 pulse normally.

Source files
------------

// File: rtl/change_dispenser_if.sv
// rtl/change_dispenser_if.sv - request/status bundle between the vending controller and the change dispenser
//
// Ports (slave = dispenser side):
//   start      in   one-cycle pay request
//   amount     in   change to pay, 10-cent units
//   hold       in   tray-full pause, freezes the inter-coin gap
//   busy       out  payout in progress
//   coin_out   out  one-hot hopper release [3]=100 [2]=50 [1]=20 [0]=10
//   remaining  out  amount still to pay
//   coins_paid out  coins released since last accepted start (saturating)
//   done       out  one-cycle completion pulse
//   short      out  residue below 10 could not be paid
interface change_dispenser_if;
  logic       start;
  logic [9:0] amount;
  logic       hold;
  logic       busy;
  logic [3:0] coin_out;
  logic [9:0] remaining;
  logic [3:0] coins_paid;
  logic       done;
  logic       short;

  modport master (
    output start, amount, hold,
    input  busy, coin_out, remaining, coins_paid, done, short
  );

  modport slave (
    input  start, amount, hold,
    output busy, coin_out, remaining, coins_paid, done, short
  );
endinterface

// File: rtl/change_dispenser.sv
// rtl/change_dispenser.sv - greedy coin payout as timed hopper-release pulses
//
// Ports:
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset
//   bus    change_dispenser_if.slave: start/amount/hold in,
//          busy/coin_out/remaining/coins_paid/done/short out
module change_dispenser #(
  parameter int PULSE_CYCLES = 10_000_000,
  parameter int GAP_CYCLES   = 10_000_000,
  parameter int CNT_W        = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  change_dispenser_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_PULSE,
    S_GAP,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q;
  logic [9:0]       remaining_q;
  logic [9:0]       denom_q;
  logic [3:0]       coins_paid_q;
  logic [3:0]       coin_q, coin_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             short_q;

  logic [3:0]       sel_onehot;
  logic [9:0]       sel_value;

  // Largest denomination not exceeding what is still owed.
  always_comb begin
    sel_onehot = 4'b0000;
    sel_value  = 10'd0;
    if (remaining_q >= 10'd100) begin
      sel_onehot = 4'b1000;
      sel_value  = 10'd100;
    end else if (remaining_q >= 10'd50) begin
      sel_onehot = 4'b0100;
      sel_value  = 10'd50;
    end else if (remaining_q >= 10'd20) begin
      sel_onehot = 4'b0010;
      sel_value  = 10'd20;
    end else if (remaining_q >= 10'd10) begin
      sel_onehot = 4'b0001;
      sel_value  = 10'd10;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (bus.start) state_d = S_SELECT;
      S_SELECT: state_d = (sel_onehot != 4'b0000) ? S_PULSE : S_DONE;
      S_PULSE:  if (timer_q == '0) state_d = S_GAP;
      S_GAP:    if (!bus.hold && timer_q == '0) state_d = S_SELECT;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs; registering coin_out keeps the
  // solenoid drive glitch-free.
  always_comb begin
    coin_d = 4'b0000;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    unique case (state_q)
      S_SELECT: coin_d = sel_onehot;
      S_PULSE:  coin_d = (timer_q == '0) ? 4'b0000 : coin_q;
      default:  coin_d = 4'b0000;
    endcase
  end

  // State register and datapath
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      remaining_q  <= '0;
      denom_q      <= '0;
      coins_paid_q <= '0;
      coin_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      short_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      coin_q  <= coin_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start) begin
            remaining_q  <= bus.amount;
            coins_paid_q <= '0;
            short_q      <= 1'b0;
          end
        end
        S_SELECT: begin
          if (sel_onehot != 4'b0000) begin
            timer_q <= CNT_W'(PULSE_CYCLES - 1);
            denom_q <= sel_value;
          end else begin
            // Entering DONE: flag a residue that no coin can cover.
            short_q <= (remaining_q != 10'd0);
          end
        end
        S_PULSE: begin
          if (timer_q == '0) begin
            remaining_q <= remaining_q - denom_q;
            if (coins_paid_q != 4'hF) coins_paid_q <= coins_paid_q + 4'd1;
            timer_q <= CNT_W'(GAP_CYCLES - 1);
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_GAP: begin
          if (!bus.hold && timer_q != '0) timer_q <= timer_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.busy       = busy_q;
  assign bus.coin_out   = coin_q;
  assign bus.remaining  = remaining_q;
  assign bus.coins_paid = coins_paid_q;
  assign bus.done       = done_q;
  assign bus.short      = short_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb/tb_change_dispenser.sv - scoreboard bench for change_dispenser
module tb_change_dispenser;
  localparam int PULSE = 4;
  localparam int GAP   = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  change_dispenser_if dif ();

  change_dispenser #(
    .PULSE_CYCLES(PULSE),
    .GAP_CYCLES  (GAP),
    .CNT_W       (24)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (dif.slave)
  );

  // One record per coin: value, width, low cycles since previous pulse end
  // (or since busy rose), remaining and coins_paid right after the pulse.
  typedef struct {
    int coin;
    int width;
    int low;
    int rem;
    int paid;
  } coin_exp_t;

  typedef struct {
    int rem;
    int shrt;
    int paid;
    int busy;
  } done_exp_t;

  coin_exp_t coin_q[$];
  done_exp_t done_q[$];
  coin_exp_t ce;
  done_exp_t de;

  int n_checks = 0;
  int n_pass   = 0;
  int done_cnt = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic void exp_coin(input int coin, input int width, input int low,
                                   input int rem, input int paid);
    coin_exp_t e;
    e.coin = coin; e.width = width; e.low = low; e.rem = rem; e.paid = paid;
    coin_q.push_back(e);
  endfunction

  function automatic void exp_done(input int rem, input int shrt, input int paid, input int busy);
    done_exp_t e;
    e.rem = rem; e.shrt = shrt; e.paid = paid; e.busy = busy;
    done_q.push_back(e);
  endfunction

  // Monitor
  logic [3:0] coin_prev = '0;
  logic [3:0] cur       = '0;
  logic       busy_prev = 1'b0;
  int width = 0, low_cnt = 0, rise_low = 0, busy_cnt = 0;
  int changed = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      coin_prev = '0;
      busy_prev = 1'b0;
      width     = 0;
      low_cnt   = 0;
      busy_cnt  = 0;
    end else begin
      if (dif.coin_out == 4'b0000 && coin_prev != 4'b0000) begin
        if (coin_q.size() == 0) begin
          n_checks++;
          $display("FAIL coin_unexpected: released %b, none scheduled", cur);
        end else begin
          ce = coin_q.pop_front();
          chk("coin_value", int'(cur), ce.coin);
          chk("coin_width", width, ce.width);
          chk("coin_low_before", rise_low, ce.low);
          chk("coin_stable", changed, 0);
          chk("remaining_after", int'(dif.remaining), ce.rem);
          chk("coins_paid_after", int'(dif.coins_paid), ce.paid);
        end
        low_cnt = 0;
      end
      if (dif.busy && !busy_prev) begin
        busy_cnt = 0;
        low_cnt  = 0;
      end
      if (dif.busy) busy_cnt++;
      if (dif.busy && dif.coin_out == 4'b0000) low_cnt++;
      if (dif.coin_out != 4'b0000 && coin_prev == 4'b0000) begin
        rise_low = low_cnt;
        width    = 0;
        cur      = dif.coin_out;
        changed  = 0;
      end
      if (dif.coin_out != 4'b0000) begin
        width++;
        if (dif.coin_out != cur) changed = 1;
      end
      if (dif.done) begin
        done_cnt++;
        if (done_q.size() == 0) begin
          n_checks++;
          $display("FAIL done_unexpected: done with remaining %0d, none scheduled", dif.remaining);
        end else begin
          de = done_q.pop_front();
          chk("done_remaining", int'(dif.remaining), de.rem);
          chk("done_short", int'(dif.short), de.shrt);
          chk("done_coins_paid", int'(dif.coins_paid), de.paid);
          chk("done_busy_cycles", busy_cnt, de.busy);
        end
      end
      coin_prev = dif.coin_out;
      busy_prev = dif.busy;
    end
  end

  task automatic issue(input int amt);
    @(posedge clk); #1;
    dif.amount = 10'(amt);
    dif.start  = 1'b1;
    @(posedge clk); #1;
    dif.start  = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 200) begin
      @(posedge clk);
      t++;
    end
    if (done_cnt < target) begin
      n_checks++;
      $display("FAIL done_timeout: done count %0d, expected %0d", done_cnt, target);
    end
    repeat (2) @(posedge clk);
  endtask

  int saved_done;

  initial begin
    dif.start  = 1'b0;
    dif.amount = '0;
    dif.hold   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", int'(dif.busy), 0);
    chk("rst_coin_out", int'(dif.coin_out), 0);
    chk("rst_remaining", int'(dif.remaining), 0);
    chk("rst_coins_paid", int'(dif.coins_paid), 0);
    chk("rst_done", int'(dif.done), 0);
    chk("rst_short", int'(dif.short), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // 180 = 100 + 50 + 20 + 10; 7 cycles per coin plus final SELECT and DONE
    exp_coin(8, 4, 1, 80, 1);
    exp_coin(4, 4, 3, 30, 2);
    exp_coin(2, 4, 3, 10, 3);
    exp_coin(1, 4, 3, 0, 4);
    exp_done(0, 0, 4, 30);
    issue(180);
    wait_done(1);

    // 35 = 20 + 10, residue 5 unpayable
    exp_coin(2, 4, 1, 15, 1);
    exp_coin(1, 4, 3, 5, 2);
    exp_done(5, 1, 2, 16);
    issue(35);
    wait_done(2);
    @(negedge clk);
    chk("short_held", int'(dif.short), 1);

    // Zero amount: done two cycles after the start edge, short cleared
    exp_done(0, 0, 0, 2);
    issue(0);
    wait_done(3);

    // 300 with an ignored 999 request during the second pulse
    exp_coin(8, 4, 1, 200, 1);
    exp_coin(8, 4, 3, 100, 2);
    exp_coin(8, 4, 3, 0, 3);
    exp_done(0, 0, 3, 23);
    issue(300);
    repeat (9) @(posedge clk); #1;
    dif.amount = 10'd999;
    dif.start  = 1'b1;
    @(posedge clk); #1;
    dif.start  = 1'b0;
    wait_done(4);

    // 30 = 20 + 10: hold 10 cycles in first gap (12-cycle gap + SELECT = 13 low),
    // then hold for 2 cycles inside the second pulse
    exp_coin(2, 4, 1, 10, 1);
    exp_coin(1, 4, 13, 0, 2);
    exp_done(0, 0, 2, 26);
    issue(30);
    repeat (5) @(posedge clk); #1;
    dif.hold = 1'b1;
    repeat (10) @(posedge clk); #1;
    dif.hold = 1'b0;
    repeat (4) @(posedge clk); #1;
    dif.hold = 1'b1;
    repeat (2) @(posedge clk); #1;
    dif.hold = 1'b0;
    wait_done(5);

    // Reset on the second cycle of a $5 pulse
    saved_done = done_cnt;
    issue(50);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_coin_out", int'(dif.coin_out), 0);
    chk("midrst_remaining", int'(dif.remaining), 0);
    chk("midrst_coins_paid", int'(dif.coins_paid), 0);
    chk("midrst_busy", int'(dif.busy), 0);
    chk("midrst_done", int'(dif.done), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    chk("midrst_no_done", done_cnt, saved_done);

    exp_coin(2, 4, 1, 0, 1);
    exp_done(0, 0, 1, 9);
    issue(20);
    wait_done(saved_done + 1);

    chk("coin_queue_empty", coin_q.size(), 0);
    chk("done_queue_empty", done_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
